// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan decoder:
//   - active-low digit-select codes for the six time digits
//   - active-low segment patterns {dp,g,f,e,d,c,b,a} for BCD 0..9
//   - digit index enum and decoder state enum
//   - decode_sel(): maps a select code to {known, digit index}
// -----------------------------------------------------------------------------
package seg_pkg;

   // Digit select codes (one bit low at a time).
   localparam logic [7:0] SEL_SEC_LO  = 8'b1101_1111;
   localparam logic [7:0] SEL_SEC_HI  = 8'b1110_1111;
   localparam logic [7:0] SEL_MIN_LO  = 8'b1111_0111;
   localparam logic [7:0] SEL_MIN_HI  = 8'b1111_1011;
   localparam logic [7:0] SEL_HOUR_LO = 8'b1111_1101;
   localparam logic [7:0] SEL_HOUR_HI = 8'b1111_1110;

   // Segment patterns, decimal point off.
   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;

   localparam int NUM_DIGITS = 6;

   typedef enum logic [2:0] {
      DIG_SEC_LO  = 3'd0,
      DIG_SEC_HI  = 3'd1,
      DIG_MIN_LO  = 3'd2,
      DIG_MIN_HI  = 3'd3,
      DIG_HOUR_LO = 3'd4,
      DIG_HOUR_HI = 3'd5
   } digit_e;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_CAPTURE,
      ST_HOLD
   } state_e;

   typedef struct packed {
      logic   known;
      digit_e idx;
   } sel_dec_t;

   function automatic sel_dec_t decode_sel(input logic [7:0] code);
      sel_dec_t d;
      d.known = 1'b1;
      d.idx   = DIG_SEC_LO;
      case (code)
         SEL_SEC_LO:  d.idx = DIG_SEC_LO;
         SEL_SEC_HI:  d.idx = DIG_SEC_HI;
         SEL_MIN_LO:  d.idx = DIG_MIN_LO;
         SEL_MIN_HI:  d.idx = DIG_MIN_HI;
         SEL_HOUR_LO: d.idx = DIG_HOUR_LO;
         SEL_HOUR_HI: d.idx = DIG_HOUR_HI;
         default:     d.known = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic sel_known(input logic [7:0] code);
      sel_dec_t d;
      d = decode_sel(code);
      return d.known;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// -----------------------------------------------------------------------------
// seg7_to_bcd
// Combinational decode of an active-low seven-segment pattern back to BCD.
// Ports:
//   seg_i [7:0] : segment pattern {dp,g,f,e,d,c,b,a}, active-low
//   bad_o       : pattern is not one of the ten digit glyphs (dp lit is bad)
//   bcd_o [3:0] : decoded digit, 0 when bad_o is set
// -----------------------------------------------------------------------------
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [7:0] seg_i,
   output logic       bad_o,
   output logic [3:0] bcd_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (an unassigned path in combinational logic infers a latch).
      bad_o = 1'b0;
      bcd_o = 4'd0;
      case (seg_i)
         SEG_0:   bcd_o = 4'd0;
         SEG_1:   bcd_o = 4'd1;
         SEG_2:   bcd_o = 4'd2;
         SEG_3:   bcd_o = 4'd3;
         SEG_4:   bcd_o = 4'd4;
         SEG_5:   bcd_o = 4'd5;
         SEG_6:   bcd_o = 4'd6;
         SEG_7:   bcd_o = 4'd7;
         SEG_8:   bcd_o = 4'd8;
         SEG_9:   bcd_o = 4'd9;
         default: bad_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Monitors a multiplexed 8-digit seven-segment time display bus, captures each
// digit once per dwell after sel has been stable, and reassembles hh:mm:ss.
// Parameters:
//   SETTLE  : cycles sel must be stable before seg is sampled (>= 2)
//   TIMEOUT : cycles without any sel change before stale asserts
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   sel [7:0]       : digit select, active-low
//   seg [7:0]       : segment pattern, active-low {dp,g,f,e,d,c,b,a}
//   hour/min/sec    : last accepted time, binary
//   valid           : 1-cycle pulse when hour/min/sec load
//   err             : 1-cycle pulse when a complete frame is rejected
//   stale           : level, scan has stopped; cleared by an accepted frame
// -----------------------------------------------------------------------------
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] sel,
   input  logic [7:0] seg,
   output logic [4:0] hour,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       valid,
   output logic       err,
   output logic       stale
);

   localparam int CNT_W = $clog2(SETTLE);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   // The cycle that enters SETTLE is count 0, so leaving at SETTLE-2 puts the
   // CAPTURE sample exactly SETTLE cycles after the first cycle of a new sel.
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 2);
   localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [7:0]           cur_sel_q;
   logic [7:0]           sel_prev_q;
   logic [TO_W-1:0]      to_cnt_q;
   logic [NUM_DIGITS-1:0] mask_q;
   logic [NUM_DIGITS-1:0] bad_q;
   logic [3:0]           digit_q [NUM_DIGITS];
   logic [4:0]           hour_q;
   logic [5:0]           min_q;
   logic [5:0]           sec_q;
   logic                 valid_q;
   logic                 err_q;
   logic                 stale_q;

   sel_dec_t   cur_dec;
   logic       new_known;
   logic       sel_moved;
   logic       capture;
   logic       frame_full;
   logic       frame_ok;
   logic       timeout_hit;
   logic       seg_bad;
   logic [3:0] seg_bcd;
   logic [6:0] sec_val;
   logic [6:0] min_val;
   logic [6:0] hour_val;

   seg7_to_bcd u_seg7_to_bcd (
      .seg_i (seg),
      .bad_o (seg_bad),
      .bcd_o (seg_bcd)
   );

   // cur_sel_q holds the code of the dwell being tracked; comparing against it
   // (rather than last cycle's sel) lets a change on the CAPTURE cycle start
   // the next dwell without losing a cycle.
   assign cur_dec     = decode_sel(cur_sel_q);
   assign new_known   = sel_known(sel);
   assign sel_moved   = (sel != cur_sel_q);
   assign capture     = (state_q == ST_CAPTURE) && cur_dec.known;
   assign frame_full  = &mask_q;
   assign timeout_hit = (sel == sel_prev_q) && (to_cnt_q == TO_LAST);

   // Frame assembly and range check, done in 7 bits before truncation.
   always_comb begin
      sec_val  = 7'(digit_q[DIG_SEC_HI])  * 7'd10 + 7'(digit_q[DIG_SEC_LO]);
      min_val  = 7'(digit_q[DIG_MIN_HI])  * 7'd10 + 7'(digit_q[DIG_MIN_LO]);
      hour_val = 7'(digit_q[DIG_HOUR_HI]) * 7'd10 + 7'(digit_q[DIG_HOUR_LO]);
      frame_ok = (bad_q == '0)
              && (digit_q[DIG_SEC_HI]  <= 4'd5)
              && (digit_q[DIG_MIN_HI]  <= 4'd5)
              && (digit_q[DIG_HOUR_HI] <= 4'd2)
              && (sec_val  < 7'd60)
              && (min_val  < 7'd60)
              && (hour_val < 7'd24);
   end

   // Dwell tracking state machine.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // registers see the same pre-edge values regardless of statement order.
      if (!rstn) begin
         state_q   <= ST_WAIT;
         cnt_q     <= '0;
         cur_sel_q <= 8'hFF;
      end else if ((state_q == ST_WAIT) ? new_known : sel_moved) begin
         // Start of a new dwell: restart the settle count on the new code.
         cur_sel_q <= sel;
         cnt_q     <= '0;
         state_q   <= new_known ? ST_SETTLE : ST_WAIT;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_CAPTURE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_CAPTURE: state_q <= ST_HOLD;
            default:    state_q <= state_q;
         endcase
      end
   end

   // Scan-activity timeout; saturates until sel moves again.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel_prev_q <= 8'hFF;
         to_cnt_q   <= '0;
      end else begin
         sel_prev_q <= sel;
         if (sel != sel_prev_q) begin
            to_cnt_q <= '0;
         end else if (to_cnt_q != TO_MAX) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
      end
   end

   // NOTE: digit storage has no reset; mask_q gates every read of it, so its
   // contents before the first capture are never used.
   always_ff @(posedge clk) begin
      if (capture) begin
         digit_q[cur_dec.idx] <= seg_bcd;
      end
   end

   // Frame bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mask_q  <= '0;
         bad_q   <= '0;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         stale_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (frame_full) begin
            mask_q <= '0;
            bad_q  <= '0;
            if (frame_ok) begin
               hour_q  <= hour_val[4:0];
               min_q   <= min_val[5:0];
               sec_q   <= sec_val[5:0];
               valid_q <= 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end else if (capture) begin
            // A recapture of an already-present digit simply overwrites it.
            mask_q[cur_dec.idx] <= 1'b1;
            bad_q[cur_dec.idx]  <= seg_bad;
         end
         // A stopped scan discards whatever partial frame was collected.
         if (timeout_hit) begin
            mask_q  <= '0;
            bad_q   <= '0;
            stale_q <= 1'b1;
         end else if (frame_full && frame_ok) begin
            stale_q <= 1'b0;
         end
      end
   end

   assign hour  = hour_q;
   assign min   = min_q;
   assign sec   = sec_q;
   assign valid = valid_q;
   assign err   = err_q;
   assign stale = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Drives scanned sel/seg traffic (seg lagging sel by one cycle) into
// seg_scan_decoder. A frame-level reference model pushes the expected
// valid/err response, values and arrival cycle into a queue; an independent
// monitor pops and compares whenever valid or err is seen.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 200;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] sel  = 8'hFF;
   logic [7:0] seg  = 8'hFF;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic       valid;
   logic       err;
   logic       stale;

   seg_scan_decoder #(
      .SETTLE  (SETTLE),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rstn  (rstn),
      .sel   (sel),
      .seg   (seg),
      .hour  (hour),
      .min   (min),
      .sec   (sec),
      .valid (valid),
      .err   (err),
      .stale (stale)
   );

   always #5 clk = ~clk;

   // Bench-side tables, written from the display conventions.
   logic [7:0] sel_code [6]  = '{8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
   logic [7:0] seg_pat  [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      bit is_valid;
      int h;
      int m;
      int s;
      int at;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   cyc    = 0;

   // Reference model: digits collected so far and the last accepted time.
   int       m_dig [6];
   bit [5:0] m_bad;
   bit [5:0] m_mask;
   int       m_h, m_m, m_s;
   int       fr_dig [6];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic model_reset();
      m_mask = '0;
      m_bad  = '0;
      m_h = 0; m_m = 0; m_s = 0;
   endtask

   task automatic model_capture(input int idx, input logic [7:0] pat, input int at);
      int  v;
      bit  b;
      int  s, m, h;
      bit  ok;
      exp_t e;
      b = 1'b1;
      v = 0;
      for (int k = 0; k < 10; k++) begin
         if (seg_pat[k] == pat) begin
            b = 1'b0;
            v = k;
         end
      end
      m_dig[idx]  = v;
      m_bad[idx]  = b;
      m_mask[idx] = 1'b1;
      if (m_mask == 6'h3F) begin
         s  = m_dig[1] * 10 + m_dig[0];
         m  = m_dig[3] * 10 + m_dig[2];
         h  = m_dig[5] * 10 + m_dig[4];
         ok = (m_bad == 0) && (m_dig[1] <= 5) && (m_dig[3] <= 5) && (m_dig[5] <= 2)
              && (s < 60) && (m < 60) && (h < 24);
         if (ok) begin
            m_h = h; m_m = m; m_s = s;
         end
         e.is_valid = ok;
         e.h  = m_h;
         e.m  = m_m;
         e.s  = m_s;
         e.at = at;
         q.push_back(e);
         m_mask = '0;
         m_bad  = '0;
      end
   endtask

   // One dwell: sel changes now (on a negedge), seg follows one cycle later.
   task automatic scan_digit(input int idx, input logic [7:0] pat, input int dwell);
      int t0;
      sel = sel_code[idx];
      t0  = cyc + 1;
      if (dwell >= SETTLE) model_capture(idx, pat, t0 + SETTLE + 1);
      @(negedge clk);
      seg = pat;
      repeat (dwell - 1) @(negedge clk);
   endtask

   task automatic gap(input int n);
      sel = 8'hFF;
      @(negedge clk);
      seg = 8'hFF;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      fr_dig[0] = s % 10; fr_dig[1] = s / 10;
      fr_dig[2] = m % 10; fr_dig[3] = m / 10;
      fr_dig[4] = h % 10; fr_dig[5] = h / 10;
   endtask

   task automatic scan_fr(input int dlo, input int dhi, input int blank_idx, input bit noisy);
      for (int i = 0; i < 6; i++) begin
         logic [7:0] pat;
         pat = (i == blank_idx) ? 8'hFF : seg_pat[fr_dig[i]];
         if (noisy && $urandom_range(0, 99) < 8) pat = 8'($urandom_range(0, 255));
         scan_digit(i, pat, int'($urandom_range(dhi, dlo)));
         if (noisy && $urandom_range(0, 99) < 10) gap(int'($urandom_range(1, 4)));
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check({name, "_response_seen"}, q.size(), 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   // Monitor: compare every valid/err pulse against the scoreboard head.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rstn && (valid || err)) begin
         pulses++;
         check("valid_err_exclusive", valid && err, 0);
         if (q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            e = q.pop_front();
            check("pulse_is_valid", valid, e.is_valid);
            check("hour", hour, e.h);
            check("min", min, e.m);
            check("sec", sec, e.s);
            check("pulse_cycle", cyc, e.at);
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int p0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_hour", hour, 0);
      check("rst_min", min, 0);
      check("rst_sec", sec, 0);
      check("rst_valid", valid, 0);
      check("rst_err", err, 0);
      check("rst_stale", stale, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Clean frame 22:46:40.
      set_time(22, 46, 40);
      scan_fr(10, 10, -1, 1'b0);
      drain("t2246");
      check("t2246_hour", hour, 22);
      check("t2246_min", min, 46);
      check("t2246_sec", sec, 40);

      // Blank pattern on min_lo: rejected, outputs hold.
      set_time(13, 57, 19);
      scan_fr(10, 10, 2, 1'b0);
      drain("blank");
      check("blank_hold_hour", hour, 22);
      check("blank_hold_sec", sec, 40);
      set_time(7, 5, 9);
      scan_fr(10, 10, -1, 1'b0);
      drain("after_blank");
      check("after_blank_hour", hour, 7);

      // Out-of-range hour 25:00:00.
      set_time(25, 0, 0);
      scan_fr(10, 10, -1, 1'b0);
      drain("h25");
      check("h25_hour_held", hour, 7);

      // Dwell one cycle too short everywhere: nothing should come out.
      p0 = pulses;
      set_time(11, 11, 11);
      scan_fr(SETTLE - 1, SETTLE - 1, -1, 1'b0);
      scan_fr(SETTLE - 1, SETTLE - 1, -1, 1'b0);
      repeat (10) @(negedge clk);
      check("short_dwell_no_pulse", pulses, p0);

      // Freeze mid-frame until stale, then a full 12:34:56.
      check("stale_before_freeze", stale, 0);
      set_time(1, 2, 3);
      for (int i = 0; i < 3; i++) scan_digit(i, seg_pat[fr_dig[i]], 10);
      repeat (TIMEOUT + 10) @(negedge clk);
      check("stale_after_freeze", stale, 1);
      m_mask = '0;
      m_bad  = '0;
      set_time(12, 34, 56);
      scan_fr(10, 10, -1, 1'b0);
      drain("resume");
      check("resume_stale_cleared", stale, 0);
      check("resume_sec", sec, 56);

      // Reset after three digits of a frame.
      set_time(11, 22, 33);
      for (int i = 0; i < 3; i++) scan_digit(i, seg_pat[fr_dig[i]], 10);
      rstn = 1'b0;
      sel  = 8'hFF;
      seg  = 8'hFF;
      #1;
      check("midrst_hour", hour, 0);
      check("midrst_min", min, 0);
      check("midrst_sec", sec, 0);
      check("midrst_stale", stale, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      p0 = pulses;
      for (int i = 3; i < 6; i++) scan_digit(i, seg_pat[fr_dig[i]], 10);
      repeat (5) @(negedge clk);
      check("midrst_no_early_pulse", pulses, p0);
      for (int i = 0; i < 3; i++) scan_digit(i, seg_pat[fr_dig[i]], 10);
      drain("midrst_refill");
      check("midrst_refill_min", min, 22);

      // Randomised traffic: noisy patterns, out-of-range digits, short dwells, gaps.
      for (int f = 0; f < 40; f++) begin
         fr_dig[0] = int'($urandom_range(0, 9));
         fr_dig[2] = int'($urandom_range(0, 9));
         fr_dig[4] = int'($urandom_range(0, 9));
         fr_dig[1] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 9));
         fr_dig[3] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 9));
         fr_dig[5] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 9));
         scan_fr(SETTLE - 1, 12, -1, 1'b1);
      end
      gap(2);
      drain("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
